// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq -- sequential binary to packed-BCD converter (double dabble).
//
// One double-dabble iteration is performed per clock. An operand is accepted
// in IDLE, converted over exactly N CONV cycles, and the result is presented
// in DONE until the consumer takes it with out_ready.
//
// Build option:
//   BIN2BCD_SEQ_SIGNED_EN  defined   -> binary_in is two's complement, the
//                                       magnitude is converted and neg
//                                       reports the sign bit.
//                          undefined -> binary_in is unsigned, neg is 0.
//
// Parameters:
//   N       binary operand width (2..64)
//   DIGITS  BCD digit count; values below the default drop high digits
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand offered
//   in_ready   converter can accept (state is IDLE)
//   binary_in  operand, sampled only on the accepting edge
//   out_valid  result available
//   out_ready  consumer takes result
//   bcd_out    packed BCD result, digit 0 in bits [3:0]
//   ndigits    number of significant digits (1 for a zero result)
//   neg        operand was negative
//   busy       state is not IDLE
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int N      = 16,
    parameter int DIGITS = (N * 301) / 1000 + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 binary_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DIGITS*4-1:0]          bcd_out,
    output logic [$clog2(DIGITS+1)-1:0]  ndigits,
    output logic                         neg,
    output logic                         busy
);

    localparam int BW  = DIGITS * 4;
    localparam int CW  = $clog2(N + 1);
    localparam int NDW = $clog2(DIGITS + 1);

    // Counter value seen during the N-th (final) CONV cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [N-1:0]      shift_r;
    logic [BW-1:0]     bcd_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_pend_r;

    logic [BW-1:0]     bcd_out_r;
    logic [NDW-1:0]    ndigits_r;
    logic              neg_r;
    logic              out_valid_r;
    logic              busy_r;

    logic [N-1:0]      mag_s;
    logic              sign_s;
    logic [BW-1:0]     bcd_adj_s;
    logic [BW-1:0]     bcd_step_s;
    logic [N-1:0]      shift_step_s;
    logic              last_s;

    // Add 3 to every digit that is 5 or more, so the following shift carries
    // correctly into the next decimal digit.
    function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic [3:0]    d;
        r = {BW{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            d = b[i*4 +: 4];
            if (d >= 4'd5) begin
                r[i*4 +: 4] = d + 4'd3;
            end else begin
                r[i*4 +: 4] = d;
            end
        end
        return r;
    endfunction

    // Index of the most significant nonzero digit plus one; a zero result
    // still reports one digit.
    function automatic logic [NDW-1:0] count_digits(input logic [BW-1:0] b);
        logic [NDW-1:0] nd;
        nd = NDW'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[i*4 +: 4] != 4'd0) begin
                nd = NDW'(i + 1);
            end else begin
                nd = nd;
            end
        end
        return nd;
    endfunction

`ifdef BIN2BCD_SEQ_SIGNED_EN
    // Two's complement magnitude; the most negative value maps to 2^(N-1),
    // which still fits in N unsigned bits.
    assign sign_s = binary_in[N-1];
    assign mag_s  = sign_s ? (~binary_in + {{(N-1){1'b0}}, 1'b1}) : binary_in;
`else
    assign sign_s = 1'b0;
    assign mag_s  = binary_in;
`endif

    // One double-dabble iteration: adjust digits, then shift the combined
    // {bcd, binary} register left by one.
    always_comb begin
        bcd_adj_s    = dd_adjust(bcd_r);
        bcd_step_s   = {bcd_adj_s[BW-2:0], shift_r[N-1]};
        shift_step_s = {shift_r[N-2:0], 1'b0};
    end

    assign last_s = (cnt_r == CNT_LAST);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_CONV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status flags that follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Conversion datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= {N{1'b0}};
            bcd_r      <= {BW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            neg_pend_r <= 1'b0;
            bcd_out_r  <= {BW{1'b0}};
            ndigits_r  <= {NDW{1'b0}};
            neg_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_r    <= mag_s;
                        bcd_r      <= {BW{1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        neg_pend_r <= sign_s;
                    end
                end
                ST_CONV: begin
                    shift_r <= shift_step_s;
                    bcd_r   <= bcd_step_s;
                    cnt_r   <= cnt_r + CW'(1);
                    // Result is captured on the edge that enters DONE, so it
                    // is stable for the whole time out_valid is high.
                    if (last_s) begin
                        bcd_out_r <= bcd_step_s;
                        ndigits_r <= count_digits(bcd_step_s);
                        neg_r     <= neg_pend_r;
                    end
                end
                ST_DONE: begin
                    // Hold everything until the consumer takes the result.
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign bcd_out   = bcd_out_r;
    assign ndigits   = ndigits_r;
    assign neg       = neg_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: an 8-bit and a 16-bit instance are
// driven with directed and random operands and compared against a decimal
// reference model computed with plain integer arithmetic.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_neg, a_busy;
    logic [7:0]  a_bin;
    logic [11:0] a_bcd;
    logic [1:0]  a_nd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_neg, b_busy;
    logic [15:0] b_bin;
    logic [19:0] b_bcd;
    logic [2:0]  b_nd;

    int checks;
    int errors;

    bin2bcd_seq #(.N(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .binary_in(a_bin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd_out(a_bcd), .ndigits(a_nd), .neg(a_neg), .busy(a_busy)
    );

    bin2bcd_seq #(.N(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .binary_in(b_bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd_out(b_bcd), .ndigits(b_nd), .neg(b_neg), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: reduce to n bits, take magnitude, peel digits with %10.
    function automatic void ref_model(input longint unsigned v, input int n,
                                      output logic [79:0] bcd, output int nd,
                                      output logic ng);
        longint unsigned mag;
        mag = v & ((64'd1 << n) - 64'd1);
        ng  = 1'b0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
        ng = ((mag >> (n - 1)) & 64'd1) != 64'd0;
        if (ng) mag = (64'd1 << n) - mag;
`endif
        bcd = '0;
        nd  = 1;
        for (int i = 0; i < 20; i++) begin
            bcd[i*4 +: 4] = 4'(mag % 10);
            if ((mag % 10) != 0) nd = i + 1;
            mag = mag / 10;
        end
    endfunction

    // Drive one operand into the 8-bit instance, measure cycles from the
    // accepting edge to out_valid (-1 on timeout), optionally stall, and
    // return the presented result after handshaking it away.
    task automatic xact8(input logic [7:0] v, input int stall, output int lat,
                         output logic [11:0] bcd, output logic [1:0] nd,
                         output logic ng);
        a_in_valid = 1'b1;
        a_bin      = v;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_bin      = 8'($urandom);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (a_out_valid) break;
            @(posedge clk); #1;
            if (a_out_valid) lat = c;
        end
        repeat (stall) begin @(posedge clk); #1; end
        bcd = a_bcd; nd = a_nd; ng = a_neg;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic xact16(input logic [15:0] v, output int lat,
                          output logic [19:0] bcd, output logic [2:0] nd,
                          output logic ng);
        b_in_valid = 1'b1;
        b_bin      = v;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_bin      = 16'($urandom);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (b_out_valid) break;
            @(posedge clk); #1;
            if (b_out_valid) lat = c;
        end
        bcd = b_bcd; nd = b_nd; ng = b_neg;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b1; a_bin = 8'd99; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_bin = 16'd0; b_out_ready = 1'b0;
        #23;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_busy !== 1'b0 ||
            a_bcd !== 12'h000 || a_nd !== 2'd0 || a_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset8 rdy=%b vld=%b busy=%b bcd=%h nd=%0d neg=%b expected 1 0 0 000 0 0",
                     a_in_ready, a_out_valid, a_busy, a_bcd, a_nd, a_neg);
        end
        checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_bcd !== 20'h0 || b_nd !== 3'd0) begin
            errors++;
            $display("FAIL reset16 rdy=%b vld=%b bcd=%h nd=%0d expected 1 0 00000 0",
                     b_in_ready, b_out_valid, b_bcd, b_nd);
        end
        a_in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset rdy=%b busy=%b expected 1 0", a_in_ready, a_busy);
        end
    endtask

    task automatic test_latency();
        int lat; logic [11:0] bcd; logic [1:0] nd; logic ng;
        logic [79:0] eb; int en; logic eg;
        logic [7:0] vals [3] = '{8'd255, 8'd0, 8'd7};
        for (int i = 0; i < 3; i++) begin
            ref_model(64'(vals[i]), 8, eb, en, eg);
            xact8(vals[i], 0, lat, bcd, nd, ng);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL latency in=%0d got %0d cycles expected 8", vals[i], lat);
            end
            checks++;
            if (bcd !== eb[11:0] || nd !== 2'(en) || ng !== eg) begin
                errors++;
                $display("FAIL directed in=%0d got bcd=%h nd=%0d neg=%b expected %h %0d %b",
                         vals[i], bcd, nd, ng, eb[11:0], en, eg);
            end
`ifndef BIN2BCD_SEQ_SIGNED_EN
            checks++;
            if ((i == 0 && (bcd !== 12'h255 || nd !== 2'd3)) ||
                (i == 1 && (bcd !== 12'h000 || nd !== 2'd1)) ||
                (i == 2 && (bcd !== 12'h007 || nd !== 2'd1))) begin
                errors++;
                $display("FAIL const_unsigned in=%0d got bcd=%h nd=%0d", vals[i], bcd, nd);
            end
`endif
        end
    endtask

`ifdef BIN2BCD_SEQ_SIGNED_EN
    task automatic test_signed();
        int lat; logic [11:0] bcd; logic [1:0] nd; logic ng;
        logic [7:0]  vals [3] = '{8'h80, 8'hFF, 8'h7F};
        logic [11:0] ebcd [3] = '{12'h128, 12'h001, 12'h127};
        logic        eneg [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            xact8(vals[i], 0, lat, bcd, nd, ng);
            checks++;
            if (bcd !== ebcd[i] || ng !== eneg[i]) begin
                errors++;
                $display("FAIL signed in=%h got bcd=%h neg=%b expected %h %b",
                         vals[i], bcd, ng, ebcd[i], eneg[i]);
            end
        end
    endtask
`endif

    task automatic test_hold16();
        logic [79:0] eb; int en; logic eg;
        int lat;
        ref_model(64'd65535, 16, eb, en, eg);
        b_in_valid = 1'b1; b_bin = 16'd65535;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_bin = 16'd1;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (b_out_valid) begin lat = c; break; end
        end
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL latency16 got %0d cycles expected 16", lat);
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin b_in_valid = 1'b1; b_bin = 16'd123; end
            if (c == 9) b_in_valid = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 || b_bcd !== eb[19:0] ||
                b_nd !== 3'(en) || b_neg !== eg) begin
                errors++;
                $display("FAIL hold16 cyc=%0d vld=%b rdy=%b bcd=%h nd=%0d expected 1 0 %h %0d",
                         c, b_out_valid, b_in_ready, b_bcd, b_nd, eb[19:0], en);
            end
        end
`ifndef BIN2BCD_SEQ_SIGNED_EN
        checks++;
        if (b_bcd !== 20'h65535 || b_nd !== 3'd5) begin
            errors++;
            $display("FAIL const16 got bcd=%h nd=%0d expected 65535 5", b_bcd, b_nd);
        end
`endif
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (b_busy !== 1'b0 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_queue16 busy=%b vld=%b rdy=%b expected 0 0 1",
                     b_busy, b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int rises; int lat; logic [11:0] bcd; logic [1:0] nd; logic ng;
        logic [79:0] eb; int en; logic eg;
        a_in_valid = 1'b1; a_bin = 8'd200;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_bcd !== 12'h000) begin
            errors++;
            $display("FAIL abort_async busy=%b vld=%b rdy=%b bcd=%h expected 0 0 1 000",
                     a_busy, a_out_valid, a_in_ready, a_bcd);
        end
        @(negedge clk); rst_n = 1'b1;
        rises = 0;
        repeat (20) begin @(posedge clk); #1; if (a_out_valid) rises++; end
        checks++;
        if (rises !== 0) begin
            errors++;
            $display("FAIL abort_no_result out_valid seen %0d cycles expected 0", rises);
        end
        ref_model(64'd42, 8, eb, en, eg);
        xact8(8'd42, 0, lat, bcd, nd, ng);
        checks++;
        if (lat !== 8 || bcd !== eb[11:0] || nd !== 2'(en) || bcd !== 12'h042 || nd !== 2'd2) begin
            errors++;
            $display("FAIL after_abort got lat=%0d bcd=%h nd=%0d expected 8 042 2", lat, bcd, nd);
        end
    endtask

    task automatic test_random();
        int lat; logic [11:0] bcd; logic [1:0] nd; logic ng;
        logic [19:0] bcd16; logic [2:0] nd16;
        logic [79:0] eb; int en; logic eg;
        logic [7:0] v8; logic [15:0] v16;
        for (int i = 0; i < 30; i++) begin
            v8 = 8'($urandom);
            ref_model(64'(v8), 8, eb, en, eg);
            xact8(v8, int'($urandom_range(0, 4)), lat, bcd, nd, ng);
            checks++;
            if (lat !== 8 || bcd !== eb[11:0] || nd !== 2'(en) || ng !== eg) begin
                errors++;
                $display("FAIL rand8 in=%h got lat=%0d bcd=%h nd=%0d neg=%b expected 8 %h %0d %b",
                         v8, lat, bcd, nd, ng, eb[11:0], en, eg);
            end
        end
        for (int i = 0; i < 20; i++) begin
            v16 = 16'($urandom);
            ref_model(64'(v16), 16, eb, en, eg);
            xact16(v16, lat, bcd16, nd16, ng);
            checks++;
            if (lat !== 16 || bcd16 !== eb[19:0] || nd16 !== 3'(en) || ng !== eg) begin
                errors++;
                $display("FAIL rand16 in=%h got lat=%0d bcd=%h nd=%0d neg=%b expected 16 %h %0d %b",
                         v16, lat, bcd16, nd16, ng, eb[19:0], en, eg);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_bcd_q [$];
        int          exp_nd_q  [$];
        logic        exp_neg_q [$];
        logic [79:0] eb; int en; logic eg;
        int acc, res, last_cyc;
        logic accepting;
        a_in_valid = 1'b1; a_out_ready = 1'b1; a_bin = 8'($urandom);
        acc = 0; res = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 12000 && res < 1000; cyc++) begin
            @(negedge clk);
            accepting = a_in_ready && a_in_valid;
            if (a_out_valid) begin
                checks++;
                if (exp_bcd_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious result bcd=%h with nothing outstanding", a_bcd);
                end else if (a_bcd !== exp_bcd_q[0] || a_nd !== 2'(exp_nd_q[0]) ||
                             a_neg !== exp_neg_q[0]) begin
                    errors++;
                    $display("FAIL b2b_value #%0d got bcd=%h nd=%0d neg=%b expected %h %0d %b",
                             res, a_bcd, a_nd, a_neg, exp_bcd_q[0], exp_nd_q[0], exp_neg_q[0]);
                end
                if (exp_bcd_q.size() != 0) begin
                    void'(exp_bcd_q.pop_front());
                    void'(exp_nd_q.pop_front());
                    void'(exp_neg_q.pop_front());
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc !== 10) begin
                        errors++;
                        $display("FAIL b2b_period got %0d cycles between results expected 10",
                                 cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                res++;
            end
            if (accepting) begin
                ref_model(64'(a_bin), 8, eb, en, eg);
                exp_bcd_q.push_back(eb[11:0]);
                exp_nd_q.push_back(en);
                exp_neg_q.push_back(eg);
                acc++;
            end
            @(posedge clk); #1;
            if (accepting) begin
                a_bin = 8'($urandom);
                if (acc == 1000) a_in_valid = 1'b0;
            end
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        checks++;
        if (res !== 1000) begin
            errors++;
            $display("FAIL b2b_count got %0d results expected 1000", res);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
`ifdef BIN2BCD_SEQ_SIGNED_EN
        test_signed();
`endif
        test_hold16();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter N, default 16: binary input width, legal range 2..64.
REQ-002 SHALL have parameter DIGITS, default (N*301)/1000+1: BCD digit count; a value below the default is a configuration error and truncates the high digits.
REQ-003 SHALL have ports: clk  input  1  rising-edge clock.
REQ-004 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid  input  1  operand offered.
REQ-006 SHALL have ports: in_ready  output  1  converter can accept.
REQ-007 SHALL have ports: binary_in  input  N  operand.
REQ-008 SHALL have ports: out_valid  output  1  result available.
REQ-009 SHALL have ports: out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports: bcd_out  output  DIGITS*4  packed BCD, digit 0 in bits [3:0].
REQ-011 SHALL have ports: ndigits  output  $clog2(DIGITS+1)  significant digit count.
REQ-012 SHALL have ports: neg  output  1  operand was negative.
REQ-013 SHALL have ports: busy  output  1  state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CONV and DONE; in_ready = (state==IDLE), combinational.
REQ-015 In IDLE, when in_valid&&in_ready, SHALL latch the magnitude into the shift register, clear the BCD field and the bit counter, and enter CONV.
REQ-016 Each CONV cycle SHALL add 3 to every BCD digit >=5 and then shift the combined register left by one bit, one double-dabble iteration per cycle.
REQ-017 After exactly N CONV cycles SHALL enter DONE; out_valid SHALL rise N cycles after the accepting edge.
REQ-018 Bit counter width SHALL be $clog2(N+1) with no wrap before the terminal count.
REQ-019 bcd_out, ndigits and neg SHALL register on entry to DONE and hold stable while out_valid=1.
REQ-020 In DONE, out_valid=1; on out_valid&&out_ready SHALL return to IDLE in the same edge; otherwise SHALL hold indefinitely.
REQ-021 in_valid during CONV or DONE SHALL be ignored; no operand is queued.
REQ-022 Throughput SHALL be at most one result per N+2 cycles with out_ready held high.
REQ-023 ndigits SHALL equal 1 + the index of the most significant nonzero digit; a zero result gives 1.
REQ-024 binary_in SHALL be sampled only on the accepting edge; later changes SHALL have no effect.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, out_valid=0, bcd_out=0, ndigits=0, neg=0, counter=0 and busy=0.
REQ-026 in_ready SHALL be 1 while rst_n is low and after release.
REQ-027 Reset during CONV or DONE SHALL abort the conversion without emitting a result; the first accept after release SHALL behave as from cold.

Configuration
REQ-028 Macro BIN2BCD_SEQ_SIGNED_EN defined: binary_in SHALL be two's complement; magnitude = |binary_in|, with -2^(N-1) giving 2^(N-1); neg = sign bit.
REQ-029 Macro BIN2BCD_SEQ_SIGNED_EN undefined: binary_in SHALL be unsigned; neg SHALL be tied 0; no negation logic.

Verification
REQ-030 N=8, DIGITS=3, unsigned: input 255 -> out_valid at accept+8 cycles, bcd_out=0x255, ndigits=3, neg=0.
REQ-031 N=8, unsigned: input 0 -> bcd_out=0x000, ndigits=1; input 7 -> bcd_out=0x007, ndigits=1.
REQ-032 N=16, DIGITS=5: input 65535 -> bcd_out=0x65535, ndigits=5; out_ready held 0 for 20 cycles -> outputs stable, in_ready=0, second in_valid ignored.
REQ-033 rst_n pulsed low at CONV cycle 4 of input 200 -> out_valid never rises; next accept of 42 -> bcd_out=0x042, ndigits=2.
REQ-034 SIGNED_EN, N=8: input 0x80 -> neg=1, bcd_out=0x128; input 0xFF -> neg=1, bcd_out=0x001; input 0x7F -> neg=0, bcd_out=0x127.
REQ-035 Back-to-back stream with in_valid and out_ready held 1: N=8 gives one result per 10 cycles, all values match a reference model over 1000 random inputs.
